// File: rtl/smem_pkg.sv
// Shared SMEM result-output definitions: header/slot layout and control states.
// Pure declarations; no timing or flow-control behaviour lives here.
package smem_pkg;
  localparam int READ_NUM_WIDTH = 6;
  localparam int READ_MAX_MEM   = 40;
  localparam int BEAT_W         = 512;

  localparam int READNUM_LSB = 0;
  localparam int READNUM_W   = 10;
  localparam int MEMSIZE_LSB = 64;
  localparam int MEMSIZE_W   = 7;
  localparam int RET_LSB     = 128;
  localparam int RET_W       = 32;

  // Two MEMs per body beat, each 113 valid bits.
  localparam int SLOT_W    = 113;
  localparam int SLOT0_LSB = 0;
  localparam int SLOT1_LSB = 256;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GRANT,
    ST_RECV,
    ST_DRAIN,
    ST_DONE
  } ctl_state_t;

  typedef struct packed {
    logic              last;
    logic [BEAT_W-1:0] data;
  } beat_t;

  function automatic logic [7:0] mem_beats(input logic [MEMSIZE_W-1:0] mem_size);
    return (8'(mem_size) + 8'd1) >> 1;
  endfunction
endpackage

// File: rtl/smem_beat_fifo.sv
// Synchronous first-word-fall-through FIFO; head visible the cycle after the push.
// Push while full is taken only alongside a pop; the caller detects drops.
module smem_beat_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 513
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [AW:0]      r_cnt;
  logic             w_pop;
  logic             w_push;

  assign empty  = (r_cnt == '0);
  assign full   = (r_cnt == (AW+1)'(DEPTH));
  assign count  = r_cnt;
  assign w_pop  = pop && !empty;
  assign w_push = push && (!full || w_pop);
  // Zero the head when empty so stale RAM never reaches the host port.
  assign dout   = empty ? '0 : r_mem[r_rd];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= din;
  end
endmodule

// File: rtl/smem_output_collector.sv
// Grants the SMEM result producer, checks group framing, buffers beats for the host.
// Beat to host_valid is 1 cycle; producer is held by stall with SKID free entries left.
module smem_output_collector #(
  parameter int FIFO_DEPTH     = 16,
  parameter int SKID           = 4,
  parameter int READ_NUM_WIDTH = smem_pkg::READ_NUM_WIDTH,
  parameter int READ_MAX_MEM   = smem_pkg::READ_MAX_MEM
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [READ_NUM_WIDTH:0]   batch_size,
  input  logic                      output_request,
  output logic                      output_permit,
  input  logic [511:0]              output_data,
  input  logic                      output_valid,
  input  logic                      output_finish,
  output logic                      stall,
  output logic [511:0]              host_data,
  output logic                      host_last,
  output logic                      host_valid,
  input  logic                      host_ready,
  output logic                      batch_done,
  output logic                      err_seq,
  output logic                      err_ovf,
  output logic [12:0]               mem_total
);
  import smem_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  ctl_state_t           r_state;
  ctl_state_t           w_state_nxt;
  logic                 r_body;
  logic                 r_last_read;
  logic [7:0]           r_rem;
  logic [READNUM_W-1:0] r_exp;
  logic [12:0]          r_mem_total;
  logic                 r_err_seq;
  logic                 r_err_ovf;
  logic                 r_stall;

  logic [READNUM_W-1:0] w_rn;
  logic [MEMSIZE_W-1:0] w_ms;
  logic [7:0]           w_rem_hdr;
  logic                 w_acc;
  logic                 w_final_read;
  logic                 w_last;
  logic                 w_body_nxt;
  logic                 w_hdr_err;
  logic                 w_fin_err;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_drop;
  logic                 w_empty;
  logic                 w_full;
  logic [CW-1:0]        w_cnt;
  logic [CW-1:0]        w_cnt_nxt;
  beat_t                w_in;
  beat_t                w_head;

  assign w_rn         = output_data[READNUM_LSB +: READNUM_W];
  assign w_ms         = output_data[MEMSIZE_LSB +: MEMSIZE_W];
  assign w_rem_hdr    = mem_beats(w_ms);
  assign w_acc        = output_valid && (r_state == ST_RECV);
  assign w_final_read = (11'(w_rn) + 11'd1) == 11'(batch_size);

  // A read's closing beat carries the batch tag only if it is the final read.
  assign w_last     = r_body ? ((r_rem == 8'd1) && r_last_read)
                             : ((w_rem_hdr == 8'd0) && w_final_read);
  assign w_body_nxt = !w_acc ? r_body : (r_body ? (r_rem != 8'd1) : (w_rem_hdr != 8'd0));

  assign w_hdr_err = w_acc && !r_body &&
                     ((w_rn != r_exp) || (w_ms > MEMSIZE_W'(READ_MAX_MEM)) ||
                      (11'(w_rn) >= 11'(batch_size)));
  assign w_fin_err = (r_state == ST_RECV) && output_finish && w_body_nxt;

  assign w_pop     = host_valid && host_ready;
  assign w_push    = w_acc && (!w_full || w_pop);
  assign w_drop    = w_acc && w_full && !w_pop;
  assign w_cnt_nxt = w_cnt + CW'(w_push) - CW'(w_pop);

  assign w_in.last = w_last;
  assign w_in.data = output_data;

  smem_beat_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(beat_t))
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (w_push),
    .din     (w_in),
    .pop     (w_pop),
    .dout    (w_head),
    .empty   (w_empty),
    .full    (w_full),
    .count   (w_cnt)
  );

  assign host_data  = w_head.data;
  assign host_last  = w_head.last;
  assign host_valid = !w_empty;
  assign stall      = r_stall;
  assign err_seq    = r_err_seq;
  assign err_ovf    = r_err_ovf;
  assign mem_total  = r_mem_total;

  always_comb begin
    w_state_nxt   = r_state;
    output_permit = 1'b0;
    batch_done    = 1'b0;
    case (r_state)
      ST_IDLE:  if (output_request) w_state_nxt = ST_GRANT;
      ST_GRANT: w_state_nxt = ST_RECV;
      ST_RECV: begin
        output_permit = 1'b1;
        if (output_finish) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        output_permit = 1'b1;
        if (w_empty) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        batch_done  = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_body      <= 1'b0;
      r_last_read <= 1'b0;
      r_rem       <= '0;
      r_exp       <= '0;
      r_mem_total <= '0;
      r_err_seq   <= 1'b0;
      r_err_ovf   <= 1'b0;
      r_stall     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_stall <= (w_cnt_nxt >= CW'(FIFO_DEPTH - SKID));
      if (r_state == ST_GRANT) begin
        r_body      <= 1'b0;
        r_last_read <= 1'b0;
        r_rem       <= '0;
        r_exp       <= '0;
        r_mem_total <= '0;
        r_err_seq   <= 1'b0;
        r_err_ovf   <= 1'b0;
      end else begin
        r_body <= w_body_nxt;
        if (w_acc) begin
          if (!r_body) begin
            r_rem       <= w_rem_hdr;
            r_mem_total <= r_mem_total + 13'(w_ms);
            r_exp       <= r_exp + READNUM_W'(1);
            r_last_read <= w_final_read;
          end else begin
            r_rem <= r_rem - 8'd1;
          end
        end
        if (w_hdr_err || w_fin_err) r_err_seq <= 1'b1;
        if (w_drop) r_err_ovf <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_smem_output_collector.sv
// Directed bench for smem_output_collector with a beat scoreboard on the host port.
module tb_smem_output_collector;
  logic         clk = 1'b0;
  logic         reset_n;
  logic [6:0]   batch_size;
  logic         output_request;
  logic         output_permit;
  logic [511:0] output_data;
  logic         output_valid;
  logic         output_finish;
  logic         stall;
  logic [511:0] host_data;
  logic         host_last;
  logic         host_valid;
  logic         host_ready;
  logic         batch_done;
  logic         err_seq;
  logic         err_ovf;
  logic [12:0]  mem_total;

  int checks = 0;
  int errors = 0;
  int pops   = 0;
  int idx;
  logic prev_stall;
  logic [512:0] sb [$];

  always #5 clk = ~clk;

  smem_output_collector dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .batch_size     (batch_size),
    .output_request (output_request),
    .output_permit  (output_permit),
    .output_data    (output_data),
    .output_valid   (output_valid),
    .output_finish  (output_finish),
    .stall          (stall),
    .host_data      (host_data),
    .host_last      (host_last),
    .host_valid     (host_valid),
    .host_ready     (host_ready),
    .batch_done     (batch_done),
    .err_seq        (err_seq),
    .err_ovf        (err_ovf),
    .mem_total      (mem_total)
  );

  task automatic chk(input string tag, input logic [519:0] got, input logic [519:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] mk_hdr(input int rn, input int ms, input int id);
    logic [511:0] b;
    b = '0;
    b[9:0]     = 10'(rn);
    b[70:64]   = 7'(ms);
    b[159:128] = 32'(id);
    b[511:480] = 32'(id);
    return b;
  endfunction

  function automatic logic [511:0] mk_body(input int id);
    logic [511:0] b;
    b = '0;
    b[112:0]   = 113'(id * 7 + 1);
    b[368:256] = 113'(id * 11 + 5);
    b[511:480] = 32'(id);
    return b;
  endfunction

  // One cycle: score the head if it is being popped, then advance past the edge.
  task automatic step();
    if (host_valid && host_ready) begin
      if (sb.size() == 0) chk("sb_underflow", 1, 0);
      else chk("pop_beat", {host_last, host_data}, sb.pop_front());
      pops++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [511:0] d, input logic last, input bit expect_push);
    output_valid = 1'b1;
    output_data  = d;
    if (expect_push) sb.push_back({last, d});
    step();
    output_valid = 1'b0;
  endtask

  task automatic start_batch(input int bs);
    batch_size     = 7'(bs);
    output_request = 1'b1;
    step();
    chk("grant_wait_permit", output_permit, 0);
    output_request = 1'b0;
    step();
    chk("grant_permit", output_permit, 1);
  endtask

  task automatic finish_batch(input string tag);
    bit got;
    host_ready    = 1'b1;
    output_finish = 1'b1;
    step();
    output_finish = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      if (batch_done) got = 1'b1;
      else step();
    end
    chk({tag, "_done_seen"}, got, 1);
    chk({tag, "_permit_low_at_done"}, output_permit, 0);
    chk({tag, "_sb_empty"}, sb.size(), 0);
    chk({tag, "_host_empty"}, host_valid, 0);
    step();
    chk({tag, "_done_one_cycle"}, batch_done, 0);
  endtask

  // Producer that reacts to stall one cycle late, 20-beat single read.
  task automatic bp_cycle();
    logic [511:0] d;
    if (!prev_stall && idx < 20) begin
      d = (idx == 0) ? mk_hdr(0, 38, 0) : mk_body(idx);
      output_valid = 1'b1;
      output_data  = d;
      sb.push_back({(idx == 19), d});
      idx++;
    end else begin
      output_valid = 1'b0;
    end
    prev_stall = stall;
    step();
  endtask

  initial begin
    reset_n        = 1'b0;
    batch_size     = '0;
    output_request = 1'b0;
    output_data    = '0;
    output_valid   = 1'b0;
    output_finish  = 1'b0;
    host_ready     = 1'b0;
    step();
    step();
    chk("rst_permit", output_permit, 0);
    chk("rst_stall", stall, 0);
    chk("rst_host_valid", host_valid, 0);
    chk("rst_host_last", host_last, 0);
    chk("rst_host_data", host_data, 0);
    chk("rst_done", batch_done, 0);
    chk("rst_err_seq", err_seq, 0);
    chk("rst_err_ovf", err_ovf, 0);
    chk("rst_mem_total", mem_total, 0);
    reset_n = 1'b1;
    step();

    // Single read, three MEMs: header + two body beats, last on the third.
    start_batch(1);
    host_ready = 1'b1;
    send(mk_hdr(0, 3, 100), 1'b0, 1);
    chk("single_lat_valid", host_valid, 1);
    send(mk_body(101), 1'b0, 1);
    send(mk_body(102), 1'b1, 1);
    finish_batch("single");
    chk("single_mem_total", mem_total, 3);
    chk("single_err_seq", err_seq, 0);

    // Zero-MEM read followed by a two-MEM read.
    start_batch(2);
    send(mk_hdr(0, 0, 200), 1'b0, 1);
    send(mk_hdr(1, 2, 201), 1'b0, 1);
    send(mk_body(202), 1'b1, 1);
    chk("zero_err_seq", err_seq, 0);
    finish_batch("zero");
    chk("zero_mem_total", mem_total, 2);
    chk("zero_err_seq_end", err_seq, 0);

    // Backpressure: host stalled while a stall-respecting producer sends 20 beats.
    start_batch(1);
    host_ready = 1'b0;
    idx        = 0;
    prev_stall = 1'b0;
    for (int c = 0; c < 20; c++) bp_cycle();
    output_valid = 1'b0;
    chk("bp_stall_high", stall, 1);
    chk("bp_sent_before_stop", idx, 13);
    chk("bp_no_ovf", err_ovf, 0);
    host_ready = 1'b1;
    for (int c = 0; c < 200 && (idx < 20 || sb.size() != 0); c++) bp_cycle();
    output_valid = 1'b0;
    chk("bp_all_sent", idx, 20);
    chk("bp_stall_released", stall, 0);
    finish_batch("bp");
    chk("bp_mem_total", mem_total, 38);
    chk("bp_ovf_end", err_ovf, 0);

    // Sequence error: read 0 then read 2.
    start_batch(3);
    send(mk_hdr(0, 0, 300), 1'b0, 1);
    chk("seq_ok_first", err_seq, 0);
    send(mk_hdr(2, 0, 301), 1'b1, 1);
    chk("seq_err_set", err_seq, 1);
    finish_batch("seq");
    step();
    chk("seq_err_held_idle", err_seq, 1);

    // Full boundary: fill, push with pop at full, then a dropped push.
    start_batch(1);
    chk("full_err_seq_cleared", err_seq, 0);
    host_ready = 1'b0;
    send(mk_hdr(0, 40, 400), 1'b0, 1);
    for (int i = 1; i < 16; i++) send(mk_body(400 + i), 1'b0, 1);
    chk("full_host_valid", host_valid, 1);
    host_ready = 1'b1;
    send(mk_body(416), 1'b0, 1);
    host_ready = 1'b0;
    chk("full_push_pop_no_ovf", err_ovf, 0);
    send(mk_body(417), 1'b0, 0);
    chk("full_drop_ovf", err_ovf, 1);
    pops       = 0;
    host_ready = 1'b1;
    for (int c = 0; c < 40 && host_valid; c++) step();
    chk("full_count_16", pops, 16);
    chk("full_err_seq_before_fin", err_seq, 0);
    finish_batch("full");
    chk("full_fin_in_body_err", err_seq, 1);
    chk("full_ovf_sticky", err_ovf, 1);

    // Mid-batch reset after five beats.
    start_batch(1);
    host_ready = 1'b0;
    send(mk_hdr(0, 10, 500), 1'b0, 1);
    for (int i = 1; i < 5; i++) send(mk_body(500 + i), 1'b0, 1);
    chk("mrst_mem_total_before", mem_total, 10);
    chk("mrst_valid_before", host_valid, 1);
    reset_n = 1'b0;
    step();
    chk("mrst_permit", output_permit, 0);
    chk("mrst_host_valid", host_valid, 0);
    chk("mrst_mem_total", mem_total, 0);
    chk("mrst_stall", stall, 0);
    chk("mrst_host_data", host_data, 0);
    sb.delete();
    reset_n = 1'b1;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
